// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// One iteration per clock, sign fix-up applied in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [1:0]       MDControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_is_div;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dz;

    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_div_ok;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_is_div = MDControl[1];
    assign w_signed = ~MDControl[0];
    assign w_b_zero = (b == '0);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_accept = (r_state == S_IDLE) & start & ~clear;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Multiply: low half holds the multiplier, shifted out LSB first
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Divide: {remainder, quotient} shift left, trial subtract the divisor
    assign w_rem_sh   = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_div_ok   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = {w_div_ok ? w_diff : w_rem_sh[WIDTH-1:0],
                         r_prod[WIDTH-2:0], w_div_ok};

    assign w_prod_fix = r_neg_lo ? -r_prod : r_prod;
    assign w_q_fix    = r_neg_lo ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    assign w_r_fix    = r_neg_hi ? -r_prod[2*WIDTH-1:WIDTH]
                                 : r_prod[2*WIDTH-1:WIDTH];
    assign w_fix_hi   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_is_div && w_b_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_prod   <= {{WIDTH{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
            if (w_is_div && w_b_zero) begin
                r_hi <= a;
                r_lo <= '1;
                r_dz <= 1'b1;
            end
        end else if (r_state == S_RUN && !clear) begin
            r_prod <= r_is_div ? w_div_next : w_mul_next;
            r_cnt  <= r_cnt + 1'b1;
        end else if (r_state == S_FIX && !clear) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
            r_dz <= 1'b0;
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations
// checked against a plain-arithmetic model of multiply and divide.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         clear;
    logic [1:0]   MDControl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] l_h;
    logic [W-1:0] l_l;
    logic         l_z;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .MDControl(MDControl),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] ia,
                                  input logic [31:0] ib,
                                  output logic [31:0] eh,
                                  output logic [31:0] el,
                                  output logic ez);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] u;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ez = 1'b0;
        eh = '0;
        el = '0;
        if (op[1] && ib == 0) begin
            eh = ia;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else begin
            case (op)
                2'b00: begin
                    u = 64'(sa * sb);
                    {eh, el} = u;
                end
                2'b01: begin
                    u = {32'b0, ia} * {32'b0, ib};
                    {eh, el} = u;
                end
                2'b10: begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
                default: begin
                    el = ia / ib;
                    eh = ia % ib;
                end
            endcase
        end
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        int          exp_lat;
        model(op, ia, ib, eh, el, ez);
        exp_lat = ez ? 0 : W + 1;
        @(negedge clk);
        MDControl = op;
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, ".busy0"}, 64'(busy), 64'(1));
        lat = -1;
        if (done) lat = 0;
        for (int k = 1; k <= W + 8 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                check({tag, ".busy_done"}, 64'(busy), 64'(1));
            end
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".dz"}, 64'(div_zero), 64'(ez));
        @(posedge clk);
        #1;
        check({tag, ".busy_end"}, 64'(busy), 64'(0));
        check({tag, ".done_end"}, 64'(done), 64'(0));
        l_h = eh;
        l_l = el;
        l_z = ez;
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          ndone;

        reset = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        MDControl = 2'b00;
        a = '0;
        b = '0;
        #3;
        check("rst.hi", 64'(hi), 64'(0));
        check("rst.lo", 64'(lo), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.dz", 64'(div_zero), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("multu_10x2", 2'b01, 32'd10, 32'd2);
        check("multu_10x2.lo_k", 64'(lo), 64'd20);
        run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        check("mult_m3x7.hi_k", 64'(hi), 64'hFFFF_FFFF);
        check("mult_m3x7.lo_k", 64'(lo), 64'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max.hi_k", 64'(hi), 64'hFFFF_FFFE);
        run_op("div_100_5", 2'b10, 32'd100, 32'd5);
        check("div_100_5.lo_k", 64'(lo), 64'd20);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2.lo_k", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7_2.hi_k", 64'(hi), 64'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.lo_k", 64'(lo), 64'h8000_0000);

        // second start during RUN must be dropped
        model(2'b01, 32'd9, 32'd11, eh, el, ez);
        @(negedge clk);
        MDControl = 2'b01;
        a = 32'd9;
        b = 32'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        MDControl = 2'b11;
        a = 32'd50;
        b = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        ndone = 0;
        for (int k = 11; k <= W + 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        check("ign.lat", 64'(lat), 64'(W + 1));
        check("ign.ndone", 64'(ndone), 64'(1));
        check("ign.hi", 64'(hi), 64'(eh));
        check("ign.lo", 64'(lo), 64'(el));
        check("ign.dz", 64'(div_zero), 64'(0));

        run_op("divu_dz", 2'b11, 32'd1234, 32'd0);
        check("divu_dz.lo_k", 64'(lo), 64'hFFFF_FFFF);

        // clear mid-operation: no done, previous results untouched
        @(negedge clk);
        MDControl = 2'b10;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr.busy", 64'(busy), 64'(0));
        ndone = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("clr.ndone", 64'(ndone), 64'(0));
        check("clr.hi", 64'(hi), 64'(l_h));
        check("clr.lo", 64'(lo), 64'(l_l));
        check("clr.dz", 64'(div_zero), 64'(l_z));

        // clear wins over start in IDLE
        @(negedge clk);
        MDControl = 2'b11;
        a = 32'd5;
        b = 32'd0;
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        check("prio.busy", 64'(busy), 64'(0));
        check("prio.done", 64'(done), 64'(0));
        check("prio.hi", 64'(hi), 64'(l_h));

        run_op("after_dz", 2'b11, 32'd77, 32'd10);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // reset in the middle of a divide
        run_op("pre_rst", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        MDControl = 2'b10;
        a = $urandom;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mrst.hi", 64'(hi), 64'(0));
        check("mrst.lo", 64'(lo), 64'(0));
        check("mrst.busy", 64'(busy), 64'(0));
        check("mrst.done", 64'(done), 64'(0));
        check("mrst.dz", 64'(div_zero), 64'(0));
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mrst.ndone", 64'(ndone), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        run_op("post_rst", 2'b01, 32'd6, 32'd7);
        check("post_rst.lo_k", 64'(lo), 64'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
